// File: rtl/disp_hm.sv
// disp_hm: HH:MM BCD reader driving a 4-digit multiplexed 7-seg display.
// Optional leading-zero blanking of the hour tens digit: DISP_HM_LZ_BLANK_EN.
module disp_hm #(
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic       disp_hm_clock,
  input  logic       disp_hm_reset,
  input  logic [1:0] disp_hm_h_msd,
  input  logic [3:0] disp_hm_h_lsd,
  input  logic [2:0] disp_hm_m_msd,
  input  logic [3:0] disp_hm_m_lsd,
  input  logic       disp_hm_sec_pulse,
  output logic [3:0] disp_hm_an,
  output logic [6:0] disp_hm_seg,
  output logic       disp_hm_colon
);

  localparam int MAXC = (DIV > GUARD) ? DIV : GUARD;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic {
    ST_GUARD,
    ST_SHOW
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nx;
  logic [1:0]     idx;
  logic [1:0]     idx_nx;
  logic           take;

  logic [1:0]     s_hm;
  logic [3:0]     s_hl;
  logic [2:0]     s_mm;
  logic [3:0]     s_ml;

  logic [3:0]     an_nx;
  logic [6:0]     seg_nx;
  logic [3:0]     an_sel;
  logic [6:0]     seg_sel;
  logic [3:0]     dig;
  logic [3:0]     lim;

  function automatic logic [6:0] dec(
    input logic [3:0] d,
    input logic [3:0] l
  );
    logic [6:0] r;
    if (d > l) begin
      r = 7'h3F;
    end else begin
      case (d)
        4'd0:    r = 7'h40;
        4'd1:    r = 7'h79;
        4'd2:    r = 7'h24;
        4'd3:    r = 7'h30;
        4'd4:    r = 7'h19;
        4'd5:    r = 7'h12;
        4'd6:    r = 7'h02;
        4'd7:    r = 7'h78;
        4'd8:    r = 7'h00;
        4'd9:    r = 7'h10;
        default: r = 7'h3F;
      endcase
    end
    return r;
  endfunction

  // Pick the digit for the current slot; slot 0 reads the live input
  // because its snapshot is captured on the very edge it is shown.
  always_comb begin
    dig    = 4'd0;
    lim    = 4'd0;
    an_sel = 4'hF;
    unique case (1'b1)
      idx == 2'd0: begin
        dig    = disp_hm_m_lsd;
        lim    = 4'd9;
        an_sel = 4'b1110;
      end
      idx == 2'd1: begin
        dig    = {1'b0, s_mm};
        lim    = 4'd5;
        an_sel = 4'b1101;
      end
      idx == 2'd2: begin
        dig    = s_hl;
        lim    = 4'd9;
        an_sel = 4'b1011;
      end
      idx == 2'd3: begin
        dig    = {2'b00, s_hm};
        lim    = 4'd2;
        an_sel = 4'b0111;
      end
    endcase
    seg_sel = dec(dig, lim);
`ifdef DISP_HM_LZ_BLANK_EN
    if (idx == 2'd3 && s_hm == 2'd0) begin
      an_sel  = 4'hF;
      seg_sel = 7'h7F;
    end
`endif
  end

  // Scan FSM: next state, counter, slot index and registered outputs.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    an_nx    = disp_hm_an;
    seg_nx   = disp_hm_seg;
    take     = 1'b0;
    unique case (state)
      ST_GUARD: begin
        if (cnt == CW'(GUARD - 1)) begin
          state_nx = ST_SHOW;
          cnt_nx   = '0;
          take     = (idx == 2'd0);
          an_nx    = an_sel;
          seg_nx   = seg_sel;
        end
      end
      ST_SHOW: begin
        if (cnt == CW'(DIV - 1)) begin
          state_nx = ST_GUARD;
          cnt_nx   = '0;
          idx_nx   = idx + 2'd1;
          an_nx    = 4'hF;
          seg_nx   = 7'h7F;
        end
      end
    endcase
  end

  // State, counter and display output registers.
  always_ff @(posedge disp_hm_clock or negedge disp_hm_reset) begin
    if (!disp_hm_reset) begin
      state       <= ST_GUARD;
      cnt         <= '0;
      idx         <= 2'd0;
      disp_hm_an  <= 4'hF;
      disp_hm_seg <= 7'h7F;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      disp_hm_an  <= an_nx;
      disp_hm_seg <= seg_nx;
    end
  end

  // Frame snapshot: all four digits latched together at frame start.
  always_ff @(posedge disp_hm_clock or negedge disp_hm_reset) begin
    if (!disp_hm_reset) begin
      s_hm <= '0;
      s_hl <= '0;
      s_mm <= '0;
      s_ml <= '0;
    end else if (take) begin
      s_hm <= disp_hm_h_msd;
      s_hl <= disp_hm_h_lsd;
      s_mm <= disp_hm_m_msd;
      s_ml <= disp_hm_m_lsd;
    end
  end

  // Colon toggles on every second pulse, independent of the scan.
  always_ff @(posedge disp_hm_clock or negedge disp_hm_reset) begin
    if (!disp_hm_reset) begin
      disp_hm_colon <= 1'b1;
    end else if (disp_hm_sec_pulse) begin
      disp_hm_colon <= ~disp_hm_colon;
    end
  end

  logic unused_ml;
  assign unused_ml = ^s_ml;

endmodule
